// File: rtl/bus6809_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bus6809_master: command-driven 6809 bus master generating E/Q clocks;  |
// | BUS6809_HALT_EN adds halt_n/ba.                     Revision 1.0       |
// +------------------------------------------------------------------------+
module bus6809_master #(
    parameter int QUARTER_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        E,
    output logic        Q,
    output logic [15:0] A,
    output logic        RW_n,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe
`ifdef BUS6809_HALT_EN
    ,
    input  logic        halt_n,
    output logic        ba
`endif
);

    localparam logic [7:0] c_QLAST = 8'(QUARTER_DIV - 1);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic [7:0]  r_qcnt;
    logic [7:0]  w_qcnt_nxt;
    logic        w_qend;
    logic        w_last;
    logic        w_run;
    logic        w_accept;

    logic        r_e;
    logic        r_q;
    logic [15:0] r_a;
    logic        r_rw_n;
    logic [7:0]  r_d_out;
    logic        r_d_oe;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic        r_busy;

`ifdef BUS6809_HALT_EN
    logic        r_ba;
    assign w_run = halt_n;
    assign ba    = r_ba;
`else
    assign w_run = 1'b1;
`endif

    assign w_qend    = (r_qcnt == c_QLAST);
    assign w_last    = w_qend && (r_phase == PH3);
    assign cmd_ready = w_last && reset_n && w_run;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_phase_nxt = r_phase;
        w_qcnt_nxt  = r_qcnt + 8'd1;
        if (w_qend) begin
            w_qcnt_nxt = 8'd0;
            case (r_phase)
                PH0:     w_phase_nxt = PH1;
                PH1:     w_phase_nxt = PH2;
                PH2:     w_phase_nxt = PH3;
                default: w_phase_nxt = PH0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PH0;
            r_qcnt  <= 8'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    // Bus outputs are registered on the next-phase value so they line up with the counters.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e         <= 1'b0;
            r_q         <= 1'b0;
            r_a         <= 16'hFFFF;
            r_rw_n      <= 1'b1;
            r_d_out     <= 8'd0;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            r_e         <= (w_phase_nxt == PH2) || (w_phase_nxt == PH3);
            r_q         <= (w_phase_nxt == PH1) || (w_phase_nxt == PH2);
            r_rsp_valid <= 1'b0;
            if (w_last) begin
                r_d_oe <= 1'b0;
                if (r_busy) begin
                    r_rsp_valid <= 1'b1;
                    if (r_rw_n) begin
                        r_rsp_rdata <= d_in;
                    end
                end
                if (w_accept) begin
                    r_busy <= 1'b1;
                    r_a    <= cmd_addr;
                    r_rw_n <= ~cmd_we;
                    if (cmd_we) begin
                        r_d_out <= cmd_wdata;
                    end
                end else begin
                    r_busy <= 1'b0;
                    r_a    <= 16'hFFFF;
                    r_rw_n <= 1'b1;
                end
            end else if (w_qend && (r_phase == PH0) && r_busy && !r_rw_n) begin
                r_d_oe <= 1'b1;
            end
        end
    end

`ifdef BUS6809_HALT_EN
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ba <= 1'b0;
        end else if (w_last) begin
            r_ba <= ~halt_n;
        end
    end
`endif

    assign E         = r_e;
    assign Q         = r_q;
    assign A         = r_a;
    assign RW_n      = r_rw_n;
    assign d_out     = r_d_out;
    assign d_oe      = r_d_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus6809_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bus6809_master: directed self-checking bench, QUARTER_DIV=4.        |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_bus6809_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        e_clk;
    logic        q_clk;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
`ifdef BUS6809_HALT_EN
    logic        halt_n;
    logic        ba;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_bad = 0;

    bus6809_master #(.QUARTER_DIV(4)) dut (
        .sys_clk   (clk),
        .reset_n   (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .E         (e_clk),
        .Q         (q_clk),
        .A         (addr),
        .RW_n      (rw_n),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe)
`ifdef BUS6809_HALT_EN
        ,
        .halt_n    (halt_n),
        .ba        (ba)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        d_in      = 8'h00;
`ifdef BUS6809_HALT_EN
        halt_n    = 1'b1;
`endif
        tick(2);
        chk("rst_E",     {31'd0, e_clk}, 32'd0);
        chk("rst_Q",     {31'd0, q_clk}, 32'd0);
        chk("rst_A",     {16'd0, addr}, 32'h0000FFFF);
        chk("rst_RW",    {31'd0, rw_n}, 32'd1);
        chk("rst_dout",  {24'd0, d_out}, 32'd0);
        chk("rst_doe",   {31'd0, d_oe}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);

        // Release: now in clock 0 of a dummy cycle.
        rst_n = 1'b1;
        #1;
        chk("c0_EQ",   {30'd0, e_clk, q_clk}, 32'd0);
        chk("c0_ready", {31'd0, cmd_ready}, 32'd0);
        tick(3);
        chk("c3_EQ",   {30'd0, e_clk, q_clk}, 32'd0);
        tick(1);
        chk("c4_EQ",   {30'd0, e_clk, q_clk}, 32'b01);
        tick(3);
        chk("c7_EQ",   {30'd0, e_clk, q_clk}, 32'b01);
        tick(1);
        chk("c8_EQ",   {30'd0, e_clk, q_clk}, 32'b11);
        tick(4);
        chk("c12_EQ",  {30'd0, e_clk, q_clk}, 32'b10);
        tick(2);
        chk("c14_ready", {31'd0, cmd_ready}, 32'd0);
        tick(1);
        chk("c15_ready", {31'd0, cmd_ready}, 32'd1);
        chk("c15_A",     {16'd0, addr}, 32'h0000FFFF);
        chk("c15_RW",    {31'd0, rw_n}, 32'd1);
        tick(1);
        chk("c16_EQ",    {30'd0, e_clk, q_clk}, 32'd0);
        chk("c16_ready", {31'd0, cmd_ready}, 32'd0);

        // Write 1234/A5, presented early; must wait for the P3 end.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h1234; cmd_wdata = 8'hA5;
        tick(15);
        chk("wr_ready", {31'd0, cmd_ready}, 32'd1);
        tick(1);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 16'hBEEF; cmd_wdata = 8'h99;
        chk("wr_A0",   {16'd0, addr}, 32'h00001234);
        chk("wr_RW0",  {31'd0, rw_n}, 32'd0);
        chk("wr_oe0",  {31'd0, d_oe}, 32'd0);
        tick(3);
        chk("wr_oe3",  {31'd0, d_oe}, 32'd0);
        tick(1);
        chk("wr_oe4",  {31'd0, d_oe}, 32'd1);
        chk("wr_dout", {24'd0, d_out}, 32'h000000A5);
        tick(11);
        chk("wr_oe15", {31'd0, d_oe}, 32'd1);
        chk("wr_A15",  {16'd0, addr}, 32'h00001234);
        chk("wr_rspv15", {31'd0, rsp_valid}, 32'd0);
        tick(1);
        chk("wr_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("wr_oe16",  {31'd0, d_oe}, 32'd0);
        chk("wr_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("dm_A",     {16'd0, addr}, 32'h0000FFFF);
        chk("dm_RW",    {31'd0, rw_n}, 32'd1);
        tick(1);
        chk("wr_rspv_end", {31'd0, rsp_valid}, 32'd0);

        // Read 8019, d_in=3C only during the last clock of P3.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h8019;
        tick(15);
        cmd_valid = 1'b0;
        chk("rd_A0",  {16'd0, addr}, 32'h00008019);
        chk("rd_RW0", {31'd0, rw_n}, 32'd1);
        chk("rd_oe0", {31'd0, d_oe}, 32'd0);
        tick(14);
        chk("rd_oe14", {31'd0, d_oe}, 32'd0);
        tick(1);
        d_in = 8'h3C;
        tick(1);
        d_in = 8'h00;
        chk("rd_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("rd_rdata", {24'd0, rsp_rdata}, 32'h0000003C);

        // Back-to-back: write 0000/11, read 0000, write 7FFF/22.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0000; cmd_wdata = 8'h11;
        tick(16);
        chk("b1_A",  {16'd0, addr}, 32'h00000000);
        chk("b1_RW", {31'd0, rw_n}, 32'd0);
        cmd_we = 1'b0; d_in = 8'h66;
        tick(4);
        chk("b1_dout", {24'd0, d_out}, 32'h00000011);
        tick(12);
        chk("b2_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("b2_A",    {16'd0, addr}, 32'h00000000);
        chk("b2_RW",   {31'd0, rw_n}, 32'd1);
        cmd_we = 1'b1; cmd_addr = 16'h7FFF; cmd_wdata = 8'h22;
        tick(15);
        chk("b2_rspv15", {31'd0, rsp_valid}, 32'd0);
        tick(1);
        cmd_valid = 1'b0; d_in = 8'h00;
        chk("b3_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("b3_rdata", {24'd0, rsp_rdata}, 32'h00000066);
        chk("b3_A",     {16'd0, addr}, 32'h00007FFF);
        chk("b3_RW",    {31'd0, rw_n}, 32'd0);
        tick(4);
        chk("b3_dout",  {24'd0, d_out}, 32'h00000022);
        chk("b3_oe",    {31'd0, d_oe}, 32'd1);
        tick(12);
        chk("b4_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("b4_A",     {16'd0, addr}, 32'h0000FFFF);
        chk("b4_rdata", {24'd0, rsp_rdata}, 32'h00000066);

        // Reset on clock 8 of a write cycle.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h4321; cmd_wdata = 8'h5C;
        tick(16);
        cmd_valid = 1'b0;
        tick(8);
        chk("ar_oe_pre", {31'd0, d_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_oe_async", {31'd0, d_oe}, 32'd0);
        chk("ar_A",        {16'd0, addr}, 32'h0000FFFF);
        tick(2);
        rst_n = 1'b1;
        #1;
        n_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid !== 1'b0) n_bad++;
            if (addr !== 16'hFFFF) n_bad++;
            if (i < 4 && (e_clk !== 1'b0 || q_clk !== 1'b0)) n_bad++;
            if (i == 15 && cmd_ready !== 1'b1) n_bad++;
            if (i == 15 && e_clk !== 1'b1) n_bad++;
            if (i != 15 && cmd_ready !== 1'b0) n_bad++;
            tick(1);
        end
        chk("ar_dummy_cycle", n_bad, 32'd0);
        chk("ar_rspv", {31'd0, rsp_valid}, 32'd0);

`ifdef BUS6809_HALT_EN
        // Now in clock 0 after the post-reset dummy cycle.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0100; d_in = 8'h4D;
        tick(15);
        tick(1);
        chk("ht_A", {16'd0, addr}, 32'h00000100);
        halt_n = 1'b0;
        tick(15);
        chk("ht_ready15", {31'd0, cmd_ready}, 32'd0);
        tick(1);
        chk("ht_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("ht_rdata", {24'd0, rsp_rdata}, 32'h0000004D);
        chk("ht_ba",    {31'd0, ba}, 32'd1);
        chk("ht_A2",    {16'd0, addr}, 32'h0000FFFF);
        tick(15);
        chk("ht_ready2", {31'd0, cmd_ready}, 32'd0);
        tick(1);
        chk("ht_ba2", {31'd0, ba}, 32'd1);
        halt_n = 1'b1;
        tick(15);
        chk("ht_ready_back", {31'd0, cmd_ready}, 32'd1);
        tick(1);
        cmd_valid = 1'b0;
        chk("ht_ba_off", {31'd0, ba}, 32'd0);
        chk("ht_A3",     {16'd0, addr}, 32'h00000100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
